// File: rtl/axi_w_store_fwd.sv
// axi_w_store_fwd: store-and-forward buffer for the AXI write data channel.
// An AW is held back until its whole W burst sits in the local FIFO, so the
// downstream slave sees AW followed by an uninterrupted W burst. Bursts longer
// than the FIFO are cut through beat by beat. AR, R and B pass straight through.
// Optional performance counters: define AXI_W_STORE_FWD_PERF_EN.

// Default AXI4+ATOP channel and bus types used when the parent does not override them.
package axi_w_store_fwd_pkg;
  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned StrbW = DataW / 8;
  localparam int unsigned UserW = 1;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [5:0]       atop;
    logic [UserW-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic [StrbW-1:0] strb;
    logic             last;
    logic [UserW-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [1:0]       resp;
    logic [UserW-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic             lock;
    logic [3:0]       cache;
    logic [2:0]       prot;
    logic [3:0]       qos;
    logic [3:0]       region;
    logic [UserW-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [1:0]       resp;
    logic             last;
    logic [UserW-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_resp_t;
endpackage

module axi_w_store_fwd #(
  parameter int unsigned WBufDepth = 16,
  parameter type axi_req_t  = axi_w_store_fwd_pkg::axi_req_t,
  parameter type axi_resp_t = axi_w_store_fwd_pkg::axi_resp_t,
  parameter type w_chan_t   = axi_w_store_fwd_pkg::w_chan_t
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  axi_req_t  slv_req_i,
  output axi_resp_t slv_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
`ifdef AXI_W_STORE_FWD_PERF_EN
  ,
  output logic [31:0] aw_hold_cycles_o,
  output logic [31:0] w_full_cycles_o,
  output logic [15:0] cut_through_cnt_o
`endif
);

  localparam int unsigned CntW = $clog2(WBufDepth + 1);
  localparam int unsigned SumW = CntW + 1;
  localparam int unsigned PtrW = (WBufDepth > 1) ? $clog2(WBufDepth) : 1;

  // FIFO storage and pointers
  w_chan_t           mem_q [WBufDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]   fill_q;

  // Burst bookkeeping
  logic [CntW-1:0]   pending_q;
  logic [CntW-1:0]   skip_q;
  logic [CntW-1:0]   released_q;

  logic              full, empty;
  logic              push, pop, last_push, pop_last;
  logic              oversize, issue_ok, aw_issue;
  logic              w_out_valid;
  w_chan_t           head;
  logic [SumW-1:0]   pend_sum, skip_sum, rel_sum, fill_sum;

  assign full  = (fill_q == CntW'(WBufDepth));
  assign empty = (fill_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // AW gating: normal bursts wait for a complete buffered burst, oversize ones cut through
  assign oversize  = (32'(slv_req_i.aw.len) + 32'd1) > WBufDepth;
  assign issue_ok  = oversize ? (pending_q == '0) : (pending_q != '0);
  assign aw_issue  = slv_req_i.aw_valid & issue_ok & mst_resp_i.aw_ready;

  assign push      = slv_req_i.w_valid & ~full;
  assign last_push = push & slv_req_i.w.last;

  // W leaves only once at least one AW is out ahead of it
  assign w_out_valid = ~empty & (released_q != '0);
  assign pop         = w_out_valid & mst_resp_i.w_ready;
  assign pop_last    = pop & head.last;

  // Bus routing: pass-through for AR/R/B and AW payload, gated handshakes for AW/W
  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.aw_valid = slv_req_i.aw_valid & issue_ok;
    mst_req_o.w        = head;
    mst_req_o.w_valid  = w_out_valid;
    slv_resp_o          = mst_resp_i;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & issue_ok;
    slv_resp_o.w_ready  = ~full;
  end

  // Next values of the counters, one bit wider so wrap-around is visible
  always_comb begin
    pend_sum = {1'b0, pending_q};
    skip_sum = {1'b0, skip_q};
    rel_sum  = {1'b0, released_q};
    fill_sum = {1'b0, fill_q};
    if (last_push) begin
      if (skip_q != '0) skip_sum = skip_sum - SumW'(1);
      else              pend_sum = pend_sum + SumW'(1);
    end
    if (aw_issue && !oversize) pend_sum = pend_sum - SumW'(1);
    if (aw_issue && oversize)  skip_sum = skip_sum + SumW'(1);
    if (aw_issue)              rel_sum  = rel_sum + SumW'(1);
    if (pop_last)              rel_sum  = rel_sum - SumW'(1);
    if (push)                  fill_sum = fill_sum + SumW'(1);
    if (pop)                   fill_sum = fill_sum - SumW'(1);
  end

  // Counter and pointer registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q  <= '0;
      skip_q     <= '0;
      released_q <= '0;
      fill_q     <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      pending_q  <= pend_sum[CntW-1:0];
      skip_q     <= skip_sum[CntW-1:0];
      released_q <= rel_sum[CntW-1:0];
      fill_q     <= fill_sum[CntW-1:0];
      if (push) wr_ptr_q <= (wr_ptr_q == PtrW'(WBufDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= (rd_ptr_q == PtrW'(WBufDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
    end
  end

  // FIFO data array; contents are qualified by fill_q so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= slv_req_i.w;
  end

`ifdef AXI_W_STORE_FWD_PERF_EN
  // Saturating performance counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      aw_hold_cycles_o  <= '0;
      w_full_cycles_o   <= '0;
      cut_through_cnt_o <= '0;
    end else begin
      if (slv_req_i.aw_valid && !issue_ok && (aw_hold_cycles_o != '1))
        aw_hold_cycles_o <= aw_hold_cycles_o + 32'd1;
      if (full && (w_full_cycles_o != '1))
        w_full_cycles_o <= w_full_cycles_o + 32'd1;
      if (aw_issue && oversize && (cut_through_cnt_o != '1))
        cut_through_cnt_o <= cut_through_cnt_o + 16'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // Sanity checks on configuration and bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (WBufDepth >= 1)
        else $error("axi_w_store_fwd: WBufDepth must be >= 1");
      assert (pend_sum[CntW] == 1'b0)
        else $error("axi_w_store_fwd: pending_q over/underflow");
      assert (skip_sum[CntW] == 1'b0)
        else $error("axi_w_store_fwd: skip_q over/underflow");
      assert (rel_sum[CntW] == 1'b0)
        else $error("axi_w_store_fwd: released_q over/underflow");
      assert ((fill_sum[CntW] == 1'b0) && (fill_sum <= SumW'(WBufDepth)))
        else $error("axi_w_store_fwd: W beat lost in FIFO");
      assert (!(full && (pending_q == '0) && (skip_q == '0) && (released_q == '0) &&
                slv_req_i.aw_valid && !oversize))
        else $error("axi_w_store_fwd: buffer full with no complete burst, W stream longer than aw.len+1");
    end
  end
`endif

endmodule

// File: tb/tb_axi_w_store_fwd.sv
// tb_axi_w_store_fwd: directed bench for axi_w_store_fwd with a 4-entry W buffer.
// Build with AXI_W_STORE_FWD_PERF_EN to also cover the performance counters.
module tb_axi_w_store_fwd;
  import axi_w_store_fwd_pkg::*;

  logic      clk = 1'b0;
  logic      rst = 1'b1;
  axi_req_t  slv_req;
  axi_resp_t slv_resp;
  axi_req_t  mst_req;
  axi_resp_t mst_resp;
`ifdef AXI_W_STORE_FWD_PERF_EN
  logic [31:0] aw_hold_cycles;
  logic [31:0] w_full_cycles;
  logic [15:0] cut_through_cnt;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  axi_w_store_fwd #(
    .WBufDepth (4),
    .axi_req_t (axi_req_t),
    .axi_resp_t(axi_resp_t),
    .w_chan_t  (w_chan_t)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_resp_o(slv_resp),
    .mst_req_o (mst_req),
    .mst_resp_i(mst_resp)
`ifdef AXI_W_STORE_FWD_PERF_EN
    ,
    .aw_hold_cycles_o (aw_hold_cycles),
    .w_full_cycles_o  (w_full_cycles),
    .cut_through_cnt_o(cut_through_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic drive_aw(input logic v, input logic [7:0] len, input logic [3:0] id);
    slv_req.aw_valid = v;
    slv_req.aw.len   = len;
    slv_req.aw.id    = id;
  endtask

  task automatic drive_w(input logic v, input logic [31:0] data, input logic last);
    slv_req.w_valid = v;
    slv_req.w.data  = data;
    slv_req.w.strb  = 4'hf;
    slv_req.w.last  = last;
  endtask

  task automatic check_counters(input string tag, input int unsigned pend,
                                input int unsigned skip, input int unsigned rel);
    check({tag, "_pending"},  32'(dut.pending_q),  32'(pend));
    check({tag, "_skip"},     32'(dut.skip_q),     32'(skip));
    check({tag, "_released"}, 32'(dut.released_q), 32'(rel));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, n_checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.id     = 4'd5;
    mst_resp.r.id     = 4'd9;

    // Reset state and pass-through
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sample();
    check("rst_mst_aw_valid", 32'(mst_req.aw_valid), 32'd0);
    check("rst_mst_w_valid",  32'(mst_req.w_valid),  32'd0);
    check("rst_slv_w_ready",  32'(slv_resp.w_ready), 32'd1);
    check("rst_fill",         32'(dut.fill_q),       32'd0);
    check_counters("rst", 0, 0, 0);
    check("rst_ar_valid_pass", 32'(mst_req.ar_valid), 32'd1);
    check("rst_ar_id_pass",    32'(mst_req.ar.id),    32'd5);
    check("rst_r_id_pass",     32'(slv_resp.r.id),    32'd9);
`ifdef AXI_W_STORE_FWD_PERF_EN
    check("rst_perf_hold", aw_hold_cycles,        32'd0);
    check("rst_perf_full", w_full_cycles,         32'd0);
    check("rst_perf_ct",   32'(cut_through_cnt),  32'd0);
`endif
    tick();
    slv_req.ar_valid = 1'b0;

    // Test 1: AW len=3 waits for all 4 beats, then W leaves back-to-back
    drive_aw(1'b1, 8'd3, 4'd1);
    slv_req.aw.atop = 6'h20;
    for (int i = 0; i < 5; i++) begin
      sample();
      check("t1_aw_hold", 32'(mst_req.aw_valid), 32'd0);
      if (i == 0) check("t1_slv_aw_ready", 32'(slv_resp.aw_ready), 32'd0);
      tick();
    end
    for (int b = 0; b < 4; b++) begin
      drive_w(1'b1, 32'(32'hA0 + b), b == 3);
      sample();
      check("t1_aw_hold_w", 32'(mst_req.aw_valid), 32'd0);
      tick();
    end
    drive_w(1'b0, 32'd0, 1'b0);
    sample();
    check("t1_aw_valid",  32'(mst_req.aw_valid), 32'd1);
    check("t1_aw_id",     32'(mst_req.aw.id),    32'd1);
    check("t1_aw_atop",   32'(mst_req.aw.atop),  32'h20);
    check("t1_w_before_aw", 32'(mst_req.w_valid), 32'd0);
    check("t1_pending",   32'(dut.pending_q),    32'd1);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    slv_req.aw.atop = 6'h00;
    for (int b = 0; b < 4; b++) begin
      sample();
      check("t1_w_valid", 32'(mst_req.w_valid), 32'd1);
      check("t1_w_data",  mst_req.w.data,       32'(32'hA0 + b));
      check("t1_w_last",  32'(mst_req.w.last),  32'(b == 3));
      tick();
    end
    sample();
    check("t1_w_idle", 32'(mst_req.w_valid), 32'd0);
    check("t1_fill",   32'(dut.fill_q),      32'd0);
    check_counters("t1_end", 0, 0, 0);
    tick();

    // Test 2: W burst len=1 arrives before its AW
    drive_w(1'b1, 32'hB0, 1'b0);
    tick();
    drive_w(1'b1, 32'hB1, 1'b1);
    tick();
    drive_w(1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      sample();
      check("t2_pending_wait", 32'(dut.pending_q), 32'd1);
      tick();
    end
    drive_aw(1'b1, 8'd1, 4'd2);
    sample();
    check("t2_aw_valid",   32'(mst_req.aw_valid), 32'd1);
    check("t2_w_before_aw", 32'(mst_req.w_valid), 32'd0);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    sample();
    check("t2_rel_b0",  32'(dut.released_q), 32'd1);
    check("t2_data_b0", mst_req.w.data,       32'hB0);
    check("t2_last_b0", 32'(mst_req.w.last),  32'd0);
    tick();
    sample();
    check("t2_rel_b1",  32'(dut.released_q), 32'd1);
    check("t2_data_b1", mst_req.w.data,       32'hB1);
    check("t2_last_b1", 32'(mst_req.w.last),  32'd1);
    tick();
    sample();
    check("t2_rel_end", 32'(dut.released_q), 32'd0);
    check("t2_w_idle",  32'(mst_req.w_valid), 32'd0);
    tick();

    // Test 3: oversize AW len=7 cuts through a 4-deep buffer
    drive_aw(1'b1, 8'd7, 4'd3);
    sample();
    check("t3_aw_valid", 32'(mst_req.aw_valid), 32'd1);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive_w(1'b1, 32'(32'hC0 + i), i == 7);
      else       drive_w(1'b0, 32'd0, 1'b0);
      sample();
      check("t3_skip",    32'(dut.skip_q),    32'(i <= 7));
      check("t3_pending", 32'(dut.pending_q), 32'd0);
      if (i == 0) begin
        check("t3_w_first_idle", 32'(mst_req.w_valid), 32'd0);
      end else begin
        check("t3_w_valid", 32'(mst_req.w_valid), 32'd1);
        check("t3_w_data",  mst_req.w.data,       32'(32'hC0 + i - 1));
        check("t3_w_last",  32'(mst_req.w.last),  32'(i == 8));
      end
      tick();
    end
    sample();
    check("t3_w_idle", 32'(mst_req.w_valid), 32'd0);
    check_counters("t3_end", 0, 0, 0);
    tick();

    // Test 4: two len=0 bursts held by a stalled slave, AR/R/B unaffected
    mst_resp.w_ready = 1'b0;
    drive_w(1'b1, 32'hD0, 1'b1);
    tick();
    drive_w(1'b1, 32'hD1, 1'b1);
    tick();
    drive_w(1'b0, 32'd0, 1'b0);
    drive_aw(1'b1, 8'd0, 4'd2);
    sample();
    check("t4_aw1_valid", 32'(mst_req.aw_valid), 32'd1);
    check("t4_aw1_id",    32'(mst_req.aw.id),    32'd2);
    tick();
    drive_aw(1'b1, 8'd0, 4'd4);
    sample();
    check("t4_aw2_valid", 32'(mst_req.aw_valid), 32'd1);
    check("t4_aw2_id",    32'(mst_req.aw.id),    32'd4);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    slv_req.ar_valid   = 1'b1;
    slv_req.ar.id      = 4'd7;
    slv_req.ar.addr    = 32'h1234;
    slv_req.r_ready    = 1'b1;
    slv_req.b_ready    = 1'b1;
    mst_resp.ar_ready  = 1'b1;
    mst_resp.r_valid   = 1'b1;
    mst_resp.r.id      = 4'd3;
    mst_resp.r.data    = 32'h55;
    mst_resp.b_valid   = 1'b1;
    mst_resp.b.id      = 4'd6;
    sample();
    check("t4_fill", 32'(dut.fill_q), 32'd2);
    check_counters("t4_held", 0, 0, 2);
    check("t4_ar_valid", 32'(mst_req.ar_valid),  32'd1);
    check("t4_ar_id",    32'(mst_req.ar.id),     32'd7);
    check("t4_ar_addr",  mst_req.ar.addr,        32'h1234);
    check("t4_ar_ready", 32'(slv_resp.ar_ready), 32'd1);
    check("t4_r_valid",  32'(slv_resp.r_valid),  32'd1);
    check("t4_r_id",     32'(slv_resp.r.id),     32'd3);
    check("t4_r_data",   slv_resp.r.data,        32'h55);
    check("t4_r_ready",  32'(mst_req.r_ready),   32'd1);
    check("t4_b_valid",  32'(slv_resp.b_valid),  32'd1);
    check("t4_b_id",     32'(slv_resp.b.id),     32'd6);
    check("t4_b_ready",  32'(mst_req.b_ready),   32'd1);
    tick();
    for (int i = 0; i < 15; i++) begin
      sample();
      check("t4_hold_valid", 32'(mst_req.w_valid), 32'd1);
      check("t4_hold_data",  mst_req.w.data,       32'hD0);
      tick();
    end
    mst_resp.w_ready = 1'b1;
    sample();
    check("t4_drain0", mst_req.w.data, 32'hD0);
    tick();
    sample();
    check("t4_drain1", mst_req.w.data, 32'hD1);
    check("t4_drain1_valid", 32'(mst_req.w_valid), 32'd1);
    tick();
    sample();
    check("t4_w_idle", 32'(mst_req.w_valid), 32'd0);
    check_counters("t4_end", 0, 0, 0);
    slv_req.ar_valid = 1'b0;
    mst_resp.r_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    tick();

    // Test 5: normal AW issue in the same cycle as the next burst's last push
    drive_w(1'b1, 32'h51, 1'b1);
    tick();
    drive_w(1'b1, 32'h52, 1'b1);
    drive_aw(1'b1, 8'd0, 4'd8);
    sample();
    check("t5_aw_a_valid", 32'(mst_req.aw_valid), 32'd1);
    check("t5_pending_before", 32'(dut.pending_q), 32'd1);
    check("t5_w_before_aw", 32'(mst_req.w_valid), 32'd0);
    tick();
    drive_w(1'b0, 32'd0, 1'b0);
    drive_aw(1'b1, 8'd0, 4'd9);
    sample();
    check("t5_pending_same", 32'(dut.pending_q), 32'd1);
    check("t5_aw_b_valid",   32'(mst_req.aw_valid), 32'd1);
    check("t5_fill",         32'(dut.fill_q),    32'd2);
    check("t5_data_a",       mst_req.w.data,     32'h51);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    sample();
    check_counters("t5_mid", 0, 0, 1);
    check("t5_data_b",  mst_req.w.data,      32'h52);
    check("t5_valid_b", 32'(mst_req.w_valid), 32'd1);
    tick();
    sample();
    check("t5_w_idle", 32'(mst_req.w_valid), 32'd0);
    check("t5_fill_end", 32'(dut.fill_q), 32'd0);
    tick();

    // Test 6: reset in the middle of a buffered burst
    drive_aw(1'b1, 8'd7, 4'd5);
    sample();
    check("t6_aw_valid", 32'(mst_req.aw_valid), 32'd1);
    tick();
    drive_aw(1'b0, 8'd0, 4'd0);
    mst_resp.w_ready = 1'b0;
    drive_w(1'b1, 32'hE0, 1'b0);
    tick();
    drive_w(1'b1, 32'hE1, 1'b0);
    tick();
    drive_w(1'b0, 32'd0, 1'b0);
    sample();
    check("t6_fill_pre", 32'(dut.fill_q), 32'd2);
    check_counters("t6_pre", 0, 1, 1);
`ifdef AXI_W_STORE_FWD_PERF_EN
    check("t6_perf_ct_pre", 32'(cut_through_cnt), 32'd2);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    mst_resp.w_ready = 1'b1;
    sample();
    check("t6_mst_w_valid",  32'(mst_req.w_valid),  32'd0);
    check("t6_mst_aw_valid", 32'(mst_req.aw_valid), 32'd0);
    check("t6_slv_w_ready",  32'(slv_resp.w_ready), 32'd1);
    check("t6_fill",         32'(dut.fill_q),       32'd0);
    check_counters("t6_post", 0, 0, 0);
`ifdef AXI_W_STORE_FWD_PERF_EN
    check("t6_perf_hold", aw_hold_cycles,       32'd0);
    check("t6_perf_full", w_full_cycles,        32'd0);
    check("t6_perf_ct",   32'(cut_through_cnt), 32'd0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
